dmem_responder: RTL

// - Responder end of the CPU data-memory bus: the CPU drives address/wren/wdata/funct3, this block answers.
// - Provides on-chip data RAM plus an MMIO window for LED, RGB PWM duty, and free-running us/ms timers.
// - Handles byte/half/word stores, and sign/zero-extended loads selected by funct3.
// - Drives the board LED and RGB outputs; sits beside the instruction ROM, under the processor top.

---
 rtl/dmem_responder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory bus responder: on-chip RAM plus an MMIO window for LED, RGB PWM duty and us/ms timers.
// Loads are registered with one-cycle latency; stores use byte enables derived from funct3 and address lane.
module dmem_responder #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
    parameter int unsigned DMEM_WORDS = 2048,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FFF0,
    parameter int unsigned CLK_HZ     = 12_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    input  logic [2:0]  funct3,
    output logic [31:0] dmem_data_out,
    output logic        misaligned,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int unsigned AW        = $clog2(DMEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DMEM_WORDS);
    localparam int unsigned US_DIV    = CLK_HZ / 1_000_000;
    localparam int unsigned PRE_W     = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [PRE_W-1:0] US_LAST = PRE_W'(US_DIV - 1);

    logic [31:0]   mem [DMEM_WORDS];

    logic [31:0]   ram_offset;
    logic [AW-1:0] word_idx;
    logic          in_ram;
    logic          in_mmio;
    logic          size_b;
    logic          size_h;
    logic          size_w;
    logic          is_signed;
    logic          mis_now;
    logic [3:0]    byte_en;
    logic [31:0]   wr_word;
    logic          wr_ok;
    logic [31:0]   mmio_word;
    logic [31:0]   raw_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   rd_data;

    logic [23:0]   rgb_duty;
    logic [7:0]    pwm_cnt;
    logic [PRE_W-1:0] us_pre;
    logic [9:0]    ms_pre;
    logic [31:0]   micros;
    logic [31:0]   millis;
    logic          us_tick;

    // Region decode; the offset compare is unsigned, so addresses below the base wrap high and fail it
    always_comb begin
        ram_offset = dmem_address - DMEM_BASE;
        word_idx   = ram_offset[AW+1:2];
        in_ram     = (dmem_address >= DMEM_BASE) && (ram_offset < RAM_BYTES);
        in_mmio    = (dmem_address[31:4] == MMIO_BASE[31:4]);
    end

    always_comb begin
        size_b    = (funct3 == 3'b000) || (funct3 == 3'b100);
        size_h    = (funct3 == 3'b001) || (funct3 == 3'b101);
        size_w    = (funct3 == 3'b010);
        is_signed = !funct3[2];
        mis_now   = (size_h && dmem_address[0]) || (size_w && (dmem_address[1:0] != 2'b00));
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        byte_en = '0;
        wr_word = dmem_data_in;
        if (size_b) begin
            byte_en = 4'b0001 << dmem_address[1:0];
            wr_word = {4{dmem_data_in[7:0]}};
        end else if (size_h) begin
            byte_en = dmem_address[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{dmem_data_in[15:0]}};
        end else if (size_w) begin
            byte_en = 4'b1111;
        end
        wr_ok = dmem_wren && !reset && !mis_now;
    end

    always_ff @(posedge clk) begin
        if (wr_ok && in_ram) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led      <= 1'b0;
            rgb_duty <= '0;
        end else if (wr_ok && in_mmio) begin
            if (dmem_address[3:2] == 2'd0 && byte_en[0]) begin
                led <= wr_word[0];
            end
            if (dmem_address[3:2] == 2'd1) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (byte_en[i]) begin
                        rgb_duty[8*i +: 8] <= wr_word[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        case (dmem_address[3:2])
            2'd0:    mmio_word = {31'd0, led};
            2'd1:    mmio_word = {8'd0, rgb_duty};
            2'd2:    mmio_word = micros;
            default: mmio_word = millis;
        endcase
    end

    // Read path sees the pre-edge RAM word, giving read-before-write on a shared edge
    always_comb begin
        if (in_ram) begin
            raw_word = mem[word_idx];
        end else if (in_mmio) begin
            raw_word = mmio_word;
        end else begin
            raw_word = '0;
        end
        case (dmem_address[1:0])
            2'd0:    byte_sel = raw_word[7:0];
            2'd1:    byte_sel = raw_word[15:8];
            2'd2:    byte_sel = raw_word[23:16];
            default: byte_sel = raw_word[31:24];
        endcase
        half_sel = dmem_address[1] ? raw_word[31:16] : raw_word[15:0];
        rd_data  = '0;
        if (mis_now) begin
            rd_data = '0;
        end else if (size_b) begin
            rd_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
        end else if (size_h) begin
            rd_data = {{16{is_signed & half_sel[15]}}, half_sel};
        end else if (size_w) begin
            rd_data = raw_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_data_out <= '0;
            misaligned    <= 1'b0;
        end else begin
            dmem_data_out <= rd_data;
            misaligned    <= mis_now;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            red     <= 1'b0;
            green   <= 1'b0;
            blue    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            red     <= (pwm_cnt < rgb_duty[23:16]);
            green   <= (pwm_cnt < rgb_duty[15:8]);
            blue    <= (pwm_cnt < rgb_duty[7:0]);
        end
    end

    assign us_tick = (us_pre == US_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            us_pre <= '0;
            ms_pre <= '0;
            micros <= '0;
            millis <= '0;
        end else begin
            us_pre <= us_tick ? '0 : us_pre + PRE_W'(1);
            if (us_tick) begin
                micros <= micros + 32'd1;
                if (ms_pre == 10'd999) begin
                    ms_pre <= '0;
                    millis <= millis + 32'd1;
                end else begin
                    ms_pre <= ms_pre + 10'd1;
                end
            end
        end
    end

endmodule
